matrix_scan_ctrl: RTL and testbench

- Drives the 4-column x 8-row RGB LED matrix from the four 24-bit column words produced by the game controller (3 bits per cell, RGB).
- Time-multiplexes columns: serially shifts one column's 24 bits into an external 24-bit shift/latch register chain, then enables that column's driver for a fixed dwell.
- Snapshots all four columns once per frame, so game-state updates never tear a frame.

---
 rtl/matrix_scan_ctrl.sv | 148 ++++++++++++++
 tb/tb_matrix_scan_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_ctrl.sv
// Column-multiplexed scanner for the 4x8 RGB LED matrix: shifts one 24-bit
// column word into the external shift/latch chain, then lights that column.
module matrix_scan_ctrl #(
    parameter int SCLK_DIV     = 4,
    parameter int DWELL_CYCLES = 12500
) (
    input  logic        CLK_50M,
    input  logic        RST,
    input  logic        enable,
    input  logic [23:0] column_0,
    input  logic [23:0] column_1,
    input  logic [23:0] column_2,
    input  logic [23:0] column_3,
    output logic        sr_data,
    output logic        sr_clk,
    output logic        sr_latch,
    output logic [3:0]  col_en,
    output logic        frame_start,
    output logic        busy
);

    localparam int PW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(SCLK_DIV - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [4:0]    BIT_LAST   = 5'd23;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH,
        DISPLAY
    } state_t;

    state_t            state;
    logic [1:0]        col_idx;
    logic [3:0][23:0]  snap;
    logic [23:0]       shreg;
    logic [4:0]        bit_cnt;
    logic [PW-1:0]     phase_cnt;
    logic [DW-1:0]     dwell_cnt;
    logic [23:0]       load_word;

    // Column 0 reads the live inputs because its snapshot is taken on the same edge.
    always_comb begin
        load_word = snap[col_idx];
        if (col_idx == 2'd0) load_word = column_0;
    end

    // NOTE: the snapshot is a handful of flops, not a RAM, so it is safe to clear on reset.
    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            col_idx     <= 2'd0;
            snap        <= '0;
            shreg       <= '0;
            bit_cnt     <= '0;
            phase_cnt   <= '0;
            dwell_cnt   <= '0;
            sr_data     <= 1'b0;
            sr_clk      <= 1'b0;
            sr_latch    <= 1'b0;
            col_en      <= 4'b0000;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else if (state != IDLE && !enable) begin
            // Dropping enable beats every in-flight transition, including end of dwell.
            state       <= IDLE;
            col_idx     <= 2'd0;
            sr_data     <= 1'b0;
            sr_clk      <= 1'b0;
            sr_latch    <= 1'b0;
            col_en      <= 4'b0000;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state       <= LOAD;
                        frame_start <= 1'b1;
                        busy        <= 1'b1;
                    end
                end

                LOAD: begin
                    frame_start <= 1'b0;
                    if (col_idx == 2'd0) snap <= {column_3, column_2, column_1, column_0};
                    shreg     <= load_word;
                    sr_data   <= load_word[23];
                    sr_clk    <= 1'b0;
                    bit_cnt   <= '0;
                    phase_cnt <= '0;
                    col_en    <= 4'b0000;
                    state     <= SHIFT;
                end

                SHIFT: begin
                    if (phase_cnt == PHASE_LAST) begin
                        phase_cnt <= '0;
                        if (!sr_clk) begin
                            sr_clk <= 1'b1;
                        end else begin
                            sr_clk <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                sr_data  <= 1'b0;
                                sr_latch <= 1'b1;
                                state    <= LATCH;
                            end else begin
                                shreg   <= {shreg[22:0], 1'b0};
                                sr_data <= shreg[22];
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end else begin
                        phase_cnt <= phase_cnt + PW'(1);
                    end
                end

                LATCH: begin
                    if (phase_cnt == PHASE_LAST) begin
                        sr_latch  <= 1'b0;
                        col_en    <= 4'b0001 << col_idx;
                        dwell_cnt <= '0;
                        state     <= DISPLAY;
                    end else begin
                        phase_cnt <= phase_cnt + PW'(1);
                    end
                end

                DISPLAY: begin
                    if (dwell_cnt == DWELL_LAST) begin
                        col_en      <= 4'b0000;
                        col_idx     <= col_idx + 2'd1;
                        frame_start <= (col_idx == 2'd3);
                        state       <= LOAD;
                    end else begin
                        dwell_cnt <= dwell_cnt + DW'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Self-checking bench for matrix_scan_ctrl: observes each column period and
// compares it with a frame-level model of snapshot, shift stream and dwell.
module tb_matrix_scan_ctrl;

    localparam int SCLK_DIV = 1;
    localparam int DWELL    = 8;
    localparam int COL_PER  = 1 + 49 * SCLK_DIV + DWELL;
    localparam int DISP_AT  = 1 + 49 * SCLK_DIV;

    logic        CLK_50M;
    logic        RST;
    logic        enable;
    logic [23:0] column_0, column_1, column_2, column_3;
    logic        sr_data, sr_clk, sr_latch, frame_start, busy;
    logic [3:0]  col_en;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [23:0] model_snap [4];
    int          model_idx = 0;
    int          prev_rise = 0, prev_fs = 0;
    bit          rise_valid = 0, fs_valid = 0;

    matrix_scan_ctrl #(.SCLK_DIV(SCLK_DIV), .DWELL_CYCLES(DWELL)) dut (
        .CLK_50M(CLK_50M), .RST(RST), .enable(enable),
        .column_0(column_0), .column_1(column_1), .column_2(column_2), .column_3(column_3),
        .sr_data(sr_data), .sr_clk(sr_clk), .sr_latch(sr_latch),
        .col_en(col_en), .frame_start(frame_start), .busy(busy)
    );

    initial begin
        CLK_50M = 1'b0;
        forever #5 CLK_50M = ~CLK_50M;
    end

    always @(posedge CLK_50M) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Columns must never be lit while the chain is being shifted or latched.
    always @(negedge CLK_50M)
        if (!RST && (sr_clk || sr_latch)) check("no_ghost", 32'(col_en), 32'd0);

    function automatic logic [31:0] all_outs();
        return {23'd0, sr_data, sr_clk, sr_latch, frame_start, busy, col_en};
    endfunction

    task automatic scramble();
        column_0 = 24'($urandom);
        column_1 = 24'($urandom);
        column_2 = 24'($urandom);
        column_3 = 24'($urandom);
    endtask

    // Entered at the negedge of a LOAD cycle; leaves at the next LOAD negedge.
    // abort_kind: 0 none, 1 drop enable at sample abort_at, 2 pulse RST there.
    task automatic observe_column(input bit rnd, input bit mid_c2,
                                  input int abort_at, input int abort_kind);
        int col = model_idx;
        logic [23:0] word = '0;
        logic [3:0]  en_seen = '0;
        logic        prev_clk = 1'b0;
        int pulses = 0, latches = 0, disp = 0, first_disp = -1;

        if (rnd && col == 0) scramble();
        if (col == 0) begin
            model_snap[0] = column_0;
            model_snap[1] = column_1;
            model_snap[2] = column_2;
            model_snap[3] = column_3;
            if (fs_valid) check("frame_period", 32'(cyc - prev_fs), 32'(4 * COL_PER));
            prev_fs  = cyc;
            fs_valid = 1;
        end
        check("frame_start", 32'(frame_start), 32'(col == 0));
        check("busy_load", 32'(busy), 32'd1);

        for (int i = 0; i < COL_PER; i++) begin
            if (sr_clk && !prev_clk) begin
                word = {word[22:0], sr_data};
                pulses++;
            end
            prev_clk = sr_clk;
            if (sr_latch) begin
                latches++;
                check("latch_data_low", 32'(sr_data), 32'd0);
            end
            if (col_en != 4'b0000) begin
                if (disp == 0) begin
                    first_disp = i;
                    if (rise_valid) check("col_rise_spacing", 32'(cyc - prev_rise), 32'(COL_PER));
                    prev_rise  = cyc;
                    rise_valid = 1;
                end
                disp++;
                en_seen |= col_en;
            end
            if (rnd && i == 30) scramble();
            if (mid_c2 && i == 52) column_2 = 24'hFFFFFF;
            if (i == abort_at && abort_kind == 1) begin
                enable = 1'b0;
                @(negedge CLK_50M);
                check("disable_outs", all_outs(), 32'd0);
                enable = 1'b1;
                @(negedge CLK_50M);
                model_idx = 0; rise_valid = 0; fs_valid = 0;
                return;
            end
            if (i == abort_at && abort_kind == 2) begin
                #2 RST = 1'b1;
                #1 check("async_rst_col_en", 32'(col_en), 32'd0);
                @(negedge CLK_50M);
                check("rst_outs", all_outs(), 32'd0);
                RST = 1'b0;
                @(negedge CLK_50M);
                model_idx = 0; rise_valid = 0; fs_valid = 0;
                return;
            end
            @(negedge CLK_50M);
        end

        check($sformatf("word_c%0d", col), 32'(word), 32'(model_snap[col]));
        check("sclk_pulses", 32'(pulses), 32'd24);
        check("latch_cycles", 32'(latches), 32'(SCLK_DIV));
        check("dwell_cycles", 32'(disp), 32'(DWELL));
        check("disp_offset", 32'(first_disp), 32'(DISP_AT));
        check("col_en_onehot", 32'(en_seen), 32'(4'b0001 << col));
        model_idx = (col + 1) % 4;
    endtask

    initial begin
        RST = 1'b1; enable = 1'b0;
        column_0 = '0; column_1 = '0; column_2 = '0; column_3 = '0;
        #1 check("reset_outs", all_outs(), 32'd0);
        repeat (3) @(negedge CLK_50M);
        RST = 1'b0;
        @(negedge CLK_50M);
        check("idle_outs", all_outs(), 32'd0);

        // Frame A: fixed pattern; column_2 changes while column 1 is lit.
        column_0 = 24'hE00000;
        enable = 1'b1;
        @(negedge CLK_50M);
        observe_column(0, 0, -1, 0);
        observe_column(0, 1, -1, 0);
        observe_column(0, 0, -1, 0);
        observe_column(0, 0, -1, 0);
        // Frame B picks up column_2 = all ones.
        for (int c = 0; c < 4; c++) observe_column(0, 0, -1, 0);
        // Random frames with mid-column input churn.
        for (int c = 0; c < 8; c++) observe_column(1, 0, -1, 0);
        // Drop enable in the middle of column 1's shift.
        observe_column(1, 0, -1, 0);
        observe_column(1, 0, 20, 1);
        // Drop enable on the very cycle column 2's dwell ends.
        observe_column(1, 0, -1, 0);
        observe_column(1, 0, -1, 0);
        observe_column(1, 0, COL_PER - 1, 1);
        for (int c = 0; c < 4; c++) observe_column(1, 0, -1, 0);
        // Reset in the middle of column 1's dwell.
        observe_column(1, 0, -1, 0);
        observe_column(1, 0, DISP_AT + 3, 2);
        for (int c = 0; c < 5; c++) observe_column(1, 0, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
